grid_input_feeder: RTL
======================

# grid_input_feeder

Frame-gated input packet buffer that sits in front of `RANCNetworkGrid_1x1` and drives its `packet_in` / `input_buffer_empty` / `ren_to_input_buffer` handshake. A host loads 30-bit packets into an internal FIFO and commits frames of N packets, one frame per picture. The feeder releases exactly N packets to the grid. It then holds `input_buffer_empty` high until the grid signals `cores_done`, and only then accepts the next frame.

## Interface
- PACKET_WIDTH, 30, width of one grid input packet
- DEPTH, 64, FIFO depth in packets; must be a power of two, at least 2
- FRAME_CNT_WIDTH, 7, width of the frame length field
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  host pushes `wr_data` into the FIFO
- wr_data  in  PACKET_WIDTH  packet to push
- full  out  1  FIFO holds DEPTH packets
- frame_len  in  FRAME_CNT_WIDTH  number of packets in the frame being committed
- frame_len_valid  in  1  host commits a frame
- frame_len_ready  out  1  feeder can accept a frame commit
- ren_to_input_buffer  in  1  grid read strobe
- input_buffer_empty  out  1  no packet is currently available to the grid
- packet_in  out  PACKET_WIDTH  packet presented to the grid
- cores_done  in  1  level from the grid; its rising edge marks the end of the frame's computation
- frame_active  out  1  high in STREAM and WAIT_DONE
- frames_done  out  16  count of completed frames; wraps modulo 2^16
- error  out  1  sticky protocol error flag; cleared only by reset

## Operation
- The FSM has three states: IDLE, STREAM, WAIT_DONE.
- IDLE
  - `frame_len_ready` = 1.
  - A commit is a cycle with `frame_len_valid` = 1; it loads `remaining` from `frame_len`.
  - After a commit with `frame_len` = 0, the next state is WAIT_DONE.
  - After a commit with `frame_len` > 0, the next state is STREAM.
- STREAM
  - `input_buffer_empty` = (`remaining` == 0) OR fifo_empty.
  - A pop is a cycle with `ren_to_input_buffer` = 1 and `input_buffer_empty` = 0.
  - A pop dequeues the FIFO head into `packet_in` and decrements `remaining`.
  - When a pop takes `remaining` to 0, the next state is WAIT_DONE.
- WAIT_DONE
  - `input_buffer_empty` = 1.
  - A `cores_done` rising edge moves the FSM to IDLE and increments `frames_done`.
- Edge detection: `cores_done` is registered once; rise = `cores_done` AND NOT cores_done_q.
- Error conditions; each sets `error`, and the offending action is otherwise ignored:
  - `ren_to_input_buffer` asserted while `input_buffer_empty` = 1.
  - `wr_en` asserted while `full` = 1; the write is dropped.
  - A `cores_done` rise while the FSM is in STREAM; the state is unchanged.
- The FIFO is written independently of the FSM, so the host may preload the next frame's packets at any time.

## Timing
- Reset values:
  - `packet_in` = 0, `input_buffer_empty` = 1, `full` = 0.
  - `frame_len_ready` = 1, `frame_active` = 0, `frames_done` = 0, `error` = 0.
  - FIFO empty, FSM in IDLE, cores_done_q = 0.
- Reset asserted mid-frame immediately returns the block to the reset state. The FIFO contents are discarded.
- `packet_in` is registered and updates on the edge where `ren_to_input_buffer` is sampled high (1-cycle read latency). It holds its value between pops.
- `input_buffer_empty` is combinational from state, `remaining` and the FIFO count.
  - Its first deassertion after a commit is one cycle after the commit edge, provided the FIFO is non-empty.
- `full` and fifo_empty are computed from a count of width log2(DEPTH)+1.
  - A write and a pop in the same cycle leave the count unchanged.
  - A write into an empty FIFO is visible (fifo_empty = 0) on the next cycle.
  - A write is accepted only if `full` = 0 at the sampling edge; a same-cycle pop does not make room.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- A `cores_done` rise in the same cycle as the final pop is checked against the pre-edge state (STREAM), so it sets `error`.

## Structure
- Shared package `ranc_feeder_pkg`:
  - PACKET_WIDTH default constant.
  - State enum (IDLE, STREAM, WAIT_DONE).
  - frames_done width constant.
- Sub-module `packet_fifo`: synchronous FIFO (wr_en, wr_data, rd_en, rd_data, count) with registered read data.
- Top level contains the FSM, the `remaining` counter, edge detection, error logic and the `frames_done` counter.

## Test plan
- Preload 3 packets (0x1, 0x2, 0x3) and commit `frame_len` = 3. Hold `ren_to_input_buffer` high:
  - `packet_in` = 0x1, 0x2, 0x3 on consecutive cycles.
  - `input_buffer_empty` = 1 from the cycle after the third pop.
  - The FSM is in WAIT_DONE.
- In WAIT_DONE, raise `cores_done` for 4 cycles: `frames_done` increments by exactly 1 and `frame_len_ready` = 1 the following cycle.
- Commit `frame_len` = 5 with only 2 packets queued:
  - The grid receives 2 packets, then `input_buffer_empty` = 1 with the FSM still in STREAM.
  - Writing 3 more packets resumes streaming, and the frame completes after 5 pops.
- Write DEPTH+1 packets with no reads: `full` = 1 after DEPTH writes, the extra write is dropped, and `error` = 1.
- Commit `frame_len` = 0: the FSM goes to WAIT_DONE, no packets are popped, and a `cores_done` rise returns it to IDLE.
- Assert `rst` low mid-STREAM after 2 of 4 pops: all outputs return to reset values, and subsequent writes start at an empty FIFO.

Source files
------------

// File: rtl/grid_input_feeder_pkg.sv
// Shared constants and state type for the grid input feeder and its FIFO.
package ranc_feeder_pkg;

    localparam int DEFAULT_PACKET_WIDTH = 30;
    localparam int FRAMES_DONE_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/grid_input_feeder_if.sv
// Host load/commit signals, grid read handshake and feeder status bundled together.
interface grid_input_feeder_if
    import ranc_feeder_pkg::*;
#(
    parameter int PACKET_WIDTH    = DEFAULT_PACKET_WIDTH,
    parameter int FRAME_CNT_WIDTH = 7
);

    logic                         wr_en;
    logic [PACKET_WIDTH-1:0]      wr_data;
    logic                         full;
    logic [FRAME_CNT_WIDTH-1:0]   frame_len;
    logic                         frame_len_valid;
    logic                         frame_len_ready;
    logic                         ren_to_input_buffer;
    logic                         input_buffer_empty;
    logic [PACKET_WIDTH-1:0]      packet_in;
    logic                         cores_done;
    logic                         frame_active;
    logic [FRAMES_DONE_WIDTH-1:0] frames_done;
    logic                         error;

    modport master (
        output wr_en, wr_data, frame_len, frame_len_valid, ren_to_input_buffer, cores_done,
        input  full, frame_len_ready, input_buffer_empty, packet_in, frame_active,
               frames_done, error
    );

    modport slave (
        input  wr_en, wr_data, frame_len, frame_len_valid, ren_to_input_buffer, cores_done,
        output full, frame_len_ready, input_buffer_empty, packet_in, frame_active,
               frames_done, error
    );

endinterface

// File: rtl/grid_input_feeder_fifo.sv
// Synchronous packet FIFO with registered read data; callers must not write when full
// nor read when empty.
module packet_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/grid_input_feeder.sv
// Frame-gated packet buffer feeding the RANC grid: releases exactly one committed frame
// of packets, then waits for the grid's cores_done rise before accepting the next frame.
module grid_input_feeder
    import ranc_feeder_pkg::*;
#(
    parameter int PACKET_WIDTH    = DEFAULT_PACKET_WIDTH,
    parameter int DEPTH           = 64,
    parameter int FRAME_CNT_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    grid_input_feeder_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_STREAM    = STREAM;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

    logic [1:0]                   state;
    logic [FRAME_CNT_WIDTH-1:0]   remaining;
    logic [FRAMES_DONE_WIDTH-1:0] frames_done;
    logic                         error;
    logic                         cores_done_q;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         buf_empty;
    logic                         pop;
    logic                         wr_accept;
    logic                         cores_rise;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign buf_empty  = (state != ST_STREAM) || (remaining == '0) || fifo_empty;
    assign pop        = bus.ren_to_input_buffer && !buf_empty;
    assign wr_accept  = bus.wr_en && !fifo_full;
    assign cores_rise = bus.cores_done && !cores_done_q;

    assign bus.full               = fifo_full;
    assign bus.input_buffer_empty = buf_empty;
    assign bus.frame_len_ready    = (state == ST_IDLE);
    assign bus.frame_active       = (state != ST_IDLE);
    assign bus.frames_done        = frames_done;
    assign bus.error              = error;

    packet_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (bus.packet_in),
        .count   (fifo_count)
    );

    // Frame sequencing: a zero-length commit skips straight to waiting for the grid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            frames_done  <= '0;
            cores_done_q <= 1'b0;
        end else begin
            cores_done_q <= bus.cores_done;
            case (state)
                ST_IDLE: begin
                    if (bus.frame_len_valid) begin
                        remaining <= bus.frame_len;
                        state     <= (bus.frame_len == '0) ? ST_WAIT_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pop) begin
                        remaining <= remaining - FRAME_CNT_WIDTH'(1);
                        if (remaining == FRAME_CNT_WIDTH'(1)) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (cores_rise) begin
                        state       <= ST_IDLE;
                        frames_done <= frames_done + FRAMES_DONE_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A grid finishing while packets are still owed is judged against the pre-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error <= 1'b0;
        end else if ((bus.ren_to_input_buffer && buf_empty) ||
                     (bus.wr_en && fifo_full) ||
                     (cores_rise && (state == ST_STREAM))) begin
            error <= 1'b1;
        end
    end

endmodule
